// File: rtl/trng_pkg.sv
// Shared types and default constants for the TRNG word-sink slice.
package trng_pkg;

   typedef enum logic [1:0] {
      WARMUP = 2'd0,
      RUN    = 2'd1,
      FAIL   = 2'd2
   } sink_state_t;

   localparam int TRNG_WIDTH      = 32;
   localparam int TRNG_REP_CUTOFF = 3;

endpackage

// File: rtl/trng_word_fifo.sv
// Power-of-two word FIFO with flush; a push into a full FIFO succeeds only if a pop frees a slot.
module trng_word_fifo
   import trng_pkg::*;
#(
   parameter int WIDTH = TRNG_WIDTH,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       not_empty,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       drop
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [LW-1:0]    level_q, level_d;
   logic             pop_ok;
   logic             push_ok;

   assign pop_ok  = pop && (level_q != '0);
   assign push_ok = push && ((level_q != LW'(DEPTH)) || pop_ok);
   assign drop    = push && !push_ok;

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      level_d = level_q;
      if (flush) begin
         wr_d    = '0;
         rd_d    = '0;
         level_d = '0;
      end else begin
         if (push_ok) wr_d = wr_q + AW'(1);
         if (pop_ok)  rd_d = rd_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         level_q <= level_d;
      end
   end

   // Storage is datapath only; validity is tracked by level_q.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem_q[wr_q] <= wr_data;
   end

   assign not_empty = (level_q != '0);
   assign rd_data   = not_empty ? mem_q[rd_q] : '0;
   assign level     = level_q;

endmodule

// File: rtl/trng_word_sink.sv
// Consumer of the parallel TRNG word stream: warm-up discard, repetition-count test,
// FIFO buffering toward a ready/valid client, sticky health/overflow flags.
module trng_word_sink
   import trng_pkg::*;
#(
   parameter int WIDTH        = TRNG_WIDTH,
   parameter int DEPTH        = 8,
   parameter int WARMUP_WORDS = 4,
   parameter int REP_CUTOFF   = TRNG_REP_CUTOFF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       in_word,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_word,
   output logic [$clog2(DEPTH):0] level,
   input  logic                   clear_err,
   output logic                   overflow,
   output logic                   health_fail
);

   localparam int WW = $clog2(WARMUP_WORDS + 1);
   localparam int RW = $clog2(REP_CUTOFF + 1);

   sink_state_t      state_q, state_d;
   logic [WW-1:0]    warm_cnt_q, warm_cnt_d;
   logic [RW-1:0]    rep_cnt_q, rep_cnt_d;
   logic [RW-1:0]    rep_new;
   logic             last_vld_q, last_vld_d;
   logic [WIDTH-1:0] last_word_q, last_word_d;
   logic             overflow_q, overflow_d;
   logic             health_fail_q, health_fail_d;
   logic             fifo_push, fifo_flush, fifo_drop, pop;

   assign pop = out_valid && out_ready;

   always_comb begin
      state_d       = state_q;
      warm_cnt_d    = warm_cnt_q;
      rep_cnt_d     = rep_cnt_q;
      rep_new       = rep_cnt_q;
      last_vld_d    = last_vld_q;
      last_word_d   = last_word_q;
      health_fail_d = health_fail_q;
      fifo_push     = 1'b0;
      fifo_flush    = 1'b0;
      case (state_q)
         WARMUP: begin
            if (in_valid) begin
               if (warm_cnt_q == WW'(WARMUP_WORDS - 1)) begin
                  state_d    = RUN;
                  warm_cnt_d = '0;
                  last_vld_d = 1'b0;
               end else begin
                  warm_cnt_d = warm_cnt_q + WW'(1);
               end
            end
         end
         RUN: begin
            if (in_valid) begin
               rep_new     = (last_vld_q && (in_word == last_word_q)) ? rep_cnt_q + RW'(1) : RW'(1);
               last_word_d = in_word;
               last_vld_d  = 1'b1;
               if (rep_new == RW'(REP_CUTOFF)) begin
                  state_d       = FAIL;
                  health_fail_d = 1'b1;
                  fifo_flush    = 1'b1;
                  rep_cnt_d     = '0;
               end else begin
                  rep_cnt_d = rep_new;
                  fifo_push = 1'b1;
               end
            end
         end
         FAIL: begin
            if (clear_err) begin
               state_d       = WARMUP;
               health_fail_d = 1'b0;
            end
         end
         default: state_d = WARMUP;
      endcase
   end

   // A drop in the same cycle as clear_err keeps the flag set.
   always_comb begin
      overflow_d = overflow_q;
      if (clear_err) overflow_d = 1'b0;
      if (fifo_drop) overflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= WARMUP;
         warm_cnt_q    <= '0;
         rep_cnt_q     <= '0;
         last_vld_q    <= 1'b0;
         overflow_q    <= 1'b0;
         health_fail_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         warm_cnt_q    <= warm_cnt_d;
         rep_cnt_q     <= rep_cnt_d;
         last_vld_q    <= last_vld_d;
         overflow_q    <= overflow_d;
         health_fail_q <= health_fail_d;
      end
   end

   always_ff @(posedge clk) begin
      last_word_q <= last_word_d;
   end

   trng_word_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .pop       (pop),
      .flush     (fifo_flush),
      .wr_data   (in_word),
      .rd_data   (out_word),
      .not_empty (out_valid),
      .level     (level),
      .drop      (fifo_drop)
   );

   assign overflow    = overflow_q;
   assign health_fail = health_fail_q;

endmodule

// File: tb/tb_trng_word_sink.sv
// Directed bench for trng_word_sink with a scoreboard queue of expected output words.
module tb_trng_word_sink;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_word;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_word;
   logic [3:0]  level;
   logic        clear_err;
   logic        overflow;
   logic        health_fail;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb_q[$];
   logic [31:0] hold_word;

   always #5 clk = ~clk;

   trng_word_sink #(
      .WIDTH        (32),
      .DEPTH        (8),
      .WARMUP_WORDS (4),
      .REP_CUTOFF   (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_word     (in_word),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_word    (out_word),
      .level       (level),
      .clear_err   (clear_err),
      .overflow    (overflow),
      .health_fail (health_fail)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs set before the call are sampled at the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] w, input bit stored);
      in_valid = 1'b1;
      in_word  = w;
      step();
      in_valid = 1'b0;
      if (stored) sb_q.push_back(w);
   endtask

   task automatic pop_chk(input string tag);
      logic [31:0] exp_w;
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      exp_w = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
      chk({tag, "_word"}, 64'(out_word), 64'(exp_w));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_word   = '0;
      out_ready = 1'b0;
      clear_err = 1'b0;
      step();
      step();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_word", 64'(out_word), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_health", 64'(health_fail), 64'd0);
      rst = 1'b1;
      step();

      // Warm-up discards the first four beats.
      for (int i = 1; i <= 4; i++) begin
         send(32'(i), 1'b0);
         chk("warm_out_valid", 64'(out_valid), 64'd0);
      end
      send(32'h5, 1'b1);
      chk("t1_level1", 64'(level), 64'd1);
      chk("t1_word5", 64'(out_word), 64'h5);
      send(32'h6, 1'b1);
      chk("t1_level2", 64'(level), 64'd2);
      pop_chk("t1_pop_a");
      pop_chk("t1_pop_b");
      chk("t1_empty", 64'(out_valid), 64'd0);

      // Constant pattern trips the repetition test on the third beat.
      send(32'hAAAA_AAAA, 1'b1);
      send(32'hAAAA_AAAA, 1'b1);
      chk("t2_level2", 64'(level), 64'd2);
      send(32'hAAAA_AAAA, 1'b0);
      sb_q.delete();
      chk("t2_health", 64'(health_fail), 64'd1);
      chk("t2_level0", 64'(level), 64'd0);
      chk("t2_out_valid", 64'(out_valid), 64'd0);
      chk("t2_out_word", 64'(out_word), 64'd0);
      send(32'h77, 1'b0);
      send(32'h78, 1'b0);
      chk("t2_ignored", 64'(level), 64'd0);

      // clear_err leaves FAIL and restarts warm-up.
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      chk("t5_health_clr", 64'(health_fail), 64'd0);
      chk("t5_ovf_clr", 64'(overflow), 64'd0);
      for (int i = 0; i < 4; i++) begin
         send(32'h50 + 32'(i), 1'b0);
         chk("t5_rewarm", 64'(level), 64'd0);
      end

      // Nine distinct words with no reader: eighth fills, ninth is dropped.
      for (int i = 0; i < 9; i++) send(32'h100 + 32'(i), (i < 8));
      chk("t3_level8", 64'(level), 64'd8);
      chk("t3_overflow", 64'(overflow), 64'd1);
      chk("t3_health", 64'(health_fail), 64'd0);

      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      chk("t4_ovf_clr", 64'(overflow), 64'd0);
      chk("t4_level_kept", 64'(level), 64'd8);

      // Full FIFO: simultaneous push and pop must both succeed.
      chk("t4_head", 64'(out_word), 64'(sb_q[0]));
      void'(sb_q.pop_front());
      in_valid  = 1'b1;
      in_word   = 32'h200;
      out_ready = 1'b1;
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sb_q.push_back(32'h200);
      chk("t4_level8", 64'(level), 64'd8);
      chk("t4_no_ovf", 64'(overflow), 64'd0);

      // Backpressure holds the head word steady.
      hold_word = out_word;
      chk("t5_hold_head", 64'(hold_word), 64'(sb_q[0]));
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_stable", 64'(out_word), 64'(hold_word));
      end
      pop_chk("t5_pop_a");
      pop_chk("t5_pop_b");
      pop_chk("t5_pop_c");
      chk("t6_level5", 64'(level), 64'd5);

      // Reset mid-operation drops everything.
      rst = 1'b0;
      step();
      rst = 1'b1;
      sb_q.delete();
      chk("t6_level0", 64'(level), 64'd0);
      chk("t6_out_valid", 64'(out_valid), 64'd0);
      chk("t6_overflow", 64'(overflow), 64'd0);
      chk("t6_health", 64'(health_fail), 64'd0);
      for (int i = 0; i < 4; i++) begin
         send(32'h300 + 32'(i), 1'b0);
         chk("t6_warm", 64'(out_valid), 64'd0);
      end
      send(32'h304, 1'b1);
      chk("t6_level1", 64'(level), 64'd1);
      pop_chk("t6_pop");
      chk("t6_drained", 64'(level), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/trng_word_sink.md
# trng_word_sink

Consumer end of the `trng_parallel32` word interface. Accepts every `word_valid`/`rand_word` beat, which arrive with no backpressure, and discards a warm-up window. It then applies a repetition-count health test, buffers passing words in a small FIFO, and serves them to a downstream client over a ready/valid handshake. Health failures and overflows are reported through sticky flags that a controller clears.

## Interface
- `WIDTH`, 32: word width in bits; matches `rand_word`.
- `DEPTH`, 8: FIFO depth in words; power of two, ≥ 2.
- `WARMUP_WORDS`, 4: number of valid input words discarded after reset or error clear; ≥ 1.
- `REP_CUTOFF`, 3: number of consecutive identical words that declares a health failure; ≥ 2.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-low reset.
- `in_valid` input 1: connects to `word_valid`; one word per asserted cycle.
- `in_word` input WIDTH: connects to `rand_word`.
- `out_valid` output 1: FIFO holds at least one word.
- `out_ready` input 1: client accepts `out_word` when both are high.
- `out_word` output WIDTH: head-of-FIFO word; 0 when `out_valid` = 0.
- `level` output $clog2(DEPTH)+1: number of words currently stored.
- `clear_err` input 1: single-cycle pulse; clears sticky flags and leaves FAIL.
- `overflow` output 1: sticky; a passing word was dropped because the FIFO was full.
- `health_fail` output 1: sticky; the repetition test tripped.

## Operation
- States: WARMUP, RUN, FAIL. Reset state is WARMUP.
- **WARMUP**
  - Each `in_valid` beat increments `warm_cnt`. Words are neither tested nor stored.
  - On the beat that makes `warm_cnt` = WARMUP_WORDS, go to RUN with `warm_cnt` = 0 and `last_vld` = 0.
- **RUN, repetition test**
  - Applied to every `in_valid` beat.
  - If `last_vld` = 0 or `in_word` ≠ `last_word`, set `rep_cnt` to 1. Otherwise `rep_cnt` increments.
  - Update `last_word` to `in_word` and set `last_vld` = 1.
  - If the new `rep_cnt` = REP_CUTOFF, the word is not stored. Go to FAIL, set `health_fail`, flush the FIFO (`level` = 0), and reset `rep_cnt`.
  - Otherwise the word is pushed.
- **RUN, push**
  - If `level` = DEPTH and no pop occurs this cycle, drop the word and set `overflow`.
  - A simultaneous pop frees a slot, so the push succeeds.
- **Pop**: occurs when `out_valid` && `out_ready`, in any state. In FAIL the FIFO is empty, so no pop can occur.
- **FAIL**
  - Input words are ignored.
  - On `clear_err`, go to WARMUP and clear both `health_fail` and `overflow`.
- `clear_err` outside FAIL clears `overflow` only.
- `clear_err` in the same cycle as a health trip or an overflow event: the event wins and its flag stays set.
- Pointers wrap modulo DEPTH. `level` counts 0..DEPTH.

## Timing
- Reset values:
  - Outputs: `out_valid` = 0, `out_word` = 0, `level` = 0, `overflow` = 0, `health_fail` = 0.
  - Internal: `warm_cnt` = 0, `rep_cnt` = 0, `last_vld` = 0.
- Push at edge N gives `out_valid` = 1 and `level` incremented after edge N. There is no same-cycle bypass from input to output.
- Pop at edge N presents the next word, or `out_valid` = 0, after edge N.
- `out_word` is stable while `out_valid` && !`out_ready`.
- A health trip at edge N gives `health_fail` = 1, `out_valid` = 0 and `level` = 0 after edge N. A pop in that same cycle is still consumed.
- Sustained throughput: one word per cycle in and out.
- Reset mid-operation: all state returns to reset values at the next edge; stored words are lost.

## Structure
- Package `trng_pkg` holds:
  - state enum `sink_state_t` (WARMUP, RUN, FAIL);
  - default constants `TRNG_WIDTH` = 32 and `TRNG_REP_CUTOFF` = 3.
- Sub-module `trng_word_fifo` (WIDTH, DEPTH) contains:
  - register array, read and write pointers, `level`;
  - push, pop and flush inputs;
  - the full-with-simultaneous-pop rule.
- Top-level `trng_word_sink` contains the FSM, the warm-up counter, the repetition test and the sticky flags.

## Test plan
1. **Warm-up.** Reset, then feed 4 words 0x1,0x2,0x3,0x4, then 0x5 and 0x6. Expect `out_valid` to stay 0 during the warm-up words; then `out_word` = 0x5 and `level` = 1, then `level` = 2.
2. **Constant pattern.** Feed 0xAAAAAAAA continuously after warm-up. The third identical beat sets `health_fail` = 1 and `level` = 0; the first two words are flushed. Later inputs are ignored until `clear_err`.
3. **Overflow.** Run with `out_ready` = 0 and feed 9 distinct words. Expect `level` = 8, `overflow` = 1, and the 9th word dropped. A subsequent pop yields the first stored word.
4. **Full with simultaneous push and pop.** At `level` = 8, push and pop in the same cycle. Expect `level` to stay 8, `overflow` to stay 0, and the new word to appear last in drain order.
5. **Recovery and backpressure.**
   - Pulse `clear_err` in FAIL: both flags go to 0, the block re-enters WARMUP, and the next 4 words are discarded.
   - Hold `out_ready` low for 3 cycles: `out_word` stays stable.
6. **Reset mid-operation.** Assert `rst` = 0 with `level` = 5. After one edge, `level` = 0, `out_valid` = 0, all flags = 0, and the state is WARMUP.
